// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, direction encoding and count type for the PWM timebase and generator
package pwm_pkg;
    localparam int PWM_COUNT_W = 16;
    localparam int PWM_PSC_W   = 8;
    typedef enum logic {PWM_DIR_DOWN = 1'b0, PWM_DIR_UP = 1'b1} pwm_dir_e;
    typedef logic [PWM_COUNT_W-1:0] count_t;
endpackage

// File: rtl/pwm_counter_if.sv
// pwm_counter_if: control/config inputs and count outputs of the PWM timebase
interface pwm_counter_if #(
    parameter int COUNT_W = 16,
    parameter int PSC_W   = 8
);
    logic               counter_en;
    logic               count_reset;
    logic [COUNT_W-1:0] period;
    logic [PSC_W-1:0]   prescale;
    logic               upnotdown;
    logic [COUNT_W-1:0] count_val;
    logic               period_wrap;
    modport master (
        output counter_en, count_reset, period, prescale, upnotdown,
        input  count_val, period_wrap
    );
    modport slave (
        input  counter_en, count_reset, period, prescale, upnotdown,
        output count_val, period_wrap
    );
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: clock divider producing a tick every prescale_i+1 enabled cycles
module pwm_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PSC_W-1:0] prescale_i,
    output logic             tick_o
);
    logic [PSC_W-1:0] psc_q, psc_d;
    // tick when the divider has reached the prescale value; clear or disable restarts the divide
    always_comb begin
        tick_o = en_i && (psc_q >= prescale_i);
        psc_d  = (clr_i || !en_i || tick_o) ? '0 : psc_q + 1'b1;
    end
    // divider state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) psc_q <= '0;
        else     psc_q <= psc_d;
    end
endmodule

// File: rtl/pwm_counter.sv
// pwm_counter: prescaled up/down timebase with wrap pulse; PWM_COUNTER_SHADOW_EN selects shadowed period/prescale
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int COUNT_W = PWM_COUNT_W,
    parameter int PSC_W   = PWM_PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    pwm_counter_if.slave     cnt_if
);
    logic [COUNT_W-1:0] count_q, count_d, period_act;
    logic [PSC_W-1:0]   prescale_act;
    logic               wrap_q, wrap_d, tick, wrap_hit;
    pwm_dir_e           dir;

    assign dir = pwm_dir_e'(cnt_if.upnotdown);

    pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk        (clk),
        .rst        (rst),
        .en_i       (cnt_if.counter_en),
        .clr_i      (cnt_if.count_reset),
        .prescale_i (prescale_act),
        .tick_o     (tick)
    );

`ifdef PWM_COUNTER_SHADOW_EN
    logic load_act;
    assign load_act = cnt_if.count_reset || !cnt_if.counter_en || (tick && wrap_hit);
    // shadow copies only change at wrap, clear or while stopped, so mid-period writes cannot glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_act   <= '0;
            prescale_act <= '0;
        end else if (load_act) begin
            period_act   <= cnt_if.period;
            prescale_act <= cnt_if.prescale;
        end
    end
`else
    assign period_act   = cnt_if.period;
    assign prescale_act = cnt_if.prescale;
`endif

    // next count and wrap pulse; out-of-range counts fold back as a wrap, clear beats a tick
    always_comb begin
        wrap_hit = (dir == PWM_DIR_UP) ? (count_q >= period_act)
                                       : ((count_q == '0) || (count_q > period_act));
        count_d  = count_q;
        wrap_d   = 1'b0;
        if (cnt_if.count_reset) begin
            count_d = '0;
        end else if (tick) begin
            wrap_d  = wrap_hit;
            count_d = (dir == PWM_DIR_UP) ? (wrap_hit ? '0 : count_q + 1'b1)
                                          : (wrap_hit ? period_act : count_q - 1'b1);
        end
    end
    // count and wrap output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt_if.count_val   = count_q;
    assign cnt_if.period_wrap = wrap_q;
endmodule

// File: tb/tb_pwm_counter.sv
// tb_pwm_counter: directed stimulus with a cycle model and literal sequence checks
module tb_pwm_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    pwm_counter_if #(.COUNT_W(16), .PSC_W(8)) bus ();

    pwm_counter dut (.clk(clk), .rst(rst), .cnt_if(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // model: counts enabled cycles since the last tick, applies the wrap rules on each tick
    int   m_cnt, m_el;
    logic m_wrap;
    int   m_pa, m_sa;
    logic m_tick, m_wr;
`ifdef PWM_COUNTER_SHADOW_EN
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pa <= 0;
            m_sa <= 0;
        end else if (bus.count_reset || !bus.counter_en || m_wr) begin
            m_pa <= int'(bus.period);
            m_sa <= int'(bus.prescale);
        end
    end
`else
    always_comb begin
        m_pa = int'(bus.period);
        m_sa = int'(bus.prescale);
    end
`endif
    always_comb begin
        m_tick = bus.counter_en && !bus.count_reset && (m_el >= m_sa);
        m_wr   = m_tick && (bus.upnotdown ? (m_cnt >= m_pa) : (m_cnt == 0 || m_cnt > m_pa));
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_el   <= 0;
            m_wrap <= 1'b0;
        end else begin
            m_wrap <= m_wr;
            m_el   <= (bus.count_reset || !bus.counter_en || m_tick) ? 0 : m_el + 1;
            if (bus.count_reset)
                m_cnt <= 0;
            else if (m_tick)
                m_cnt <= bus.upnotdown ? (m_wr ? 0 : m_cnt + 1) : (m_wr ? m_pa : m_cnt - 1);
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("model_count", int'(bus.count_val), m_cnt);
            check("model_wrap", int'(bus.period_wrap), int'(m_wrap));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.count_reset = 1'b1;
        step();
        bus.count_reset = 1'b0;
    endtask

    task automatic expect_cw(input string name, input int c, input int w);
        step();
        check({name, "_count"}, int'(bus.count_val), c);
        check({name, "_wrap"}, int'(bus.period_wrap), w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2;
        bit found;
        int c1[6] = '{1, 2, 3, 4, 0, 1};
        int w1[6] = '{0, 0, 0, 0, 1, 0};
        int c3[10] = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 2};
        int w3[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        int c3u[4] = '{3, 4, 5, 0};
        int w3u[4] = '{0, 0, 0, 1};
`ifdef PWM_COUNTER_SHADOW_EN
        int c5[7] = '{6, 7, 8, 0, 1, 2, 0};
        int w5[7] = '{0, 0, 0, 1, 0, 0, 1};
`else
        int c5[4] = '{0, 1, 2, 0};
        int w5[4] = '{1, 0, 0, 1};
`endif
        bus.counter_en  = 1'b0;
        bus.count_reset = 1'b0;
        bus.period      = 16'd4;
        bus.prescale    = 8'd0;
        bus.upnotdown   = 1'b1;
        step();
        step();
        check("reset_count", int'(bus.count_val), 0);
        check("reset_wrap", int'(bus.period_wrap), 0);
        rst = 1'b0;
        step();
        bus.counter_en = 1'b1;
        foreach (c1[i]) expect_cw("t1_up", c1[i], w1[i]);

        bus.count_reset = 1'b1;
        bus.period      = 16'd3;
        bus.prescale    = 8'd2;
        step();
        bus.count_reset = 1'b0;
        expect_cw("t2_psc_a", 0, 0);
        expect_cw("t2_psc_b", 0, 0);
        expect_cw("t2_psc_c", 1, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = bus.period_wrap;
        end
        t1 = cyc;
        check("t2_first_wrap_seen", int'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = bus.period_wrap;
        end
        t2 = cyc;
        check("t2_second_wrap_seen", int'(found), 1);
        check("t2_wrap_interval", t2 - t1, 12);

        bus.count_reset = 1'b1;
        bus.upnotdown   = 1'b0;
        bus.period      = 16'd5;
        bus.prescale    = 8'd0;
        step();
        bus.count_reset = 1'b0;
        foreach (c3[i]) expect_cw("t3_down", c3[i], w3[i]);
        bus.upnotdown = 1'b1;
        foreach (c3u[i]) expect_cw("t3_flip", c3u[i], w3u[i]);

        bus.count_reset = 1'b1;
        bus.period      = 16'd4;
        step();
        bus.count_reset = 1'b0;
        for (int i = 1; i <= 4; i++) expect_cw("t4_run", i, 0);
        bus.count_reset = 1'b1;
        expect_cw("t4_clear_beats_wrap", 0, 0);
        bus.count_reset = 1'b0;
        step();
        expect_cw("t4_pre_hold", 2, 0);
        bus.counter_en = 1'b0;
        bus.prescale   = 8'd2;
        for (int i = 0; i < 10; i++) expect_cw("t4_frozen", 2, 0);
        bus.counter_en = 1'b1;
        expect_cw("t4_resume_a", 2, 0);
        expect_cw("t4_resume_b", 2, 0);
        expect_cw("t4_resume_c", 3, 0);

        bus.prescale    = 8'd0;
        bus.period      = 16'd8;
        bus.count_reset = 1'b1;
        step();
        bus.count_reset = 1'b0;
        for (int i = 1; i <= 5; i++) expect_cw("t5_run", i, 0);
        bus.period = 16'd2;
        foreach (c5[i]) expect_cw("t5_period_write", c5[i], w5[i]);

        bus.period      = 16'd0;
        bus.prescale    = 8'd1;
        bus.count_reset = 1'b1;
        step();
        bus.count_reset = 1'b0;
        expect_cw("t6_p0_a", 0, 0);
        expect_cw("t6_p0_b", 0, 1);
        expect_cw("t6_p0_c", 0, 0);
        expect_cw("t6_p0_d", 0, 1);
        rst = 1'b1;
        #1;
        check("t6_async_rst_count", int'(bus.count_val), 0);
        check("t6_async_rst_wrap", int'(bus.period_wrap), 0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
